// File: rtl/mmio_pkg.sv
// mmio_pkg
// Shared definitions for the memory-mapped output port: register offsets
// within the 16-byte window (word index a[3:2]), STATUS bit positions and
// a packed view of the STATUS word.
// Ports: none (package).
package mmio_pkg;

    localparam logic [1:0] OFF_DATA   = 2'd0;
    localparam logic [1:0] OFF_STATUS = 2'd1;
    localparam logic [1:0] OFF_TXCNT  = 2'd2;

    localparam int ST_EMPTY = 8;
    localparam int ST_FULL  = 9;
    localparam int ST_OVF   = 10;

    // Field order is MSB first, so count lands in [7:0] and the flags sit at
    // ST_EMPTY/ST_FULL/ST_OVF.
    typedef struct packed {
        logic [20:0] rsvd;
        logic        overflow;
        logic        full;
        logic        empty;
        logic [7:0]  count;
    } status_t;

endpackage

// File: rtl/mmio_outport_if.sv
// mmio_outport_if
// Bundles the CPU data-bus responder signals and the outbound valid/ready
// stream of the output port.
// Ports (signals):
//   we, a, wd   CPU store strobe, byte address, store data
//   rd          load data back to the CPU (0 outside the window)
//   out_valid   stream word available
//   out_data    stream word
//   out_ready   sink accepts the word
// Modports: master (CPU + sink side), slave (the peripheral).
interface mmio_outport_if;
    logic        we;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_ready;

    modport master (
        output we, a, wd, out_ready,
        input  rd, out_valid, out_data
    );

    modport slave (
        input  we, a, wd, out_ready,
        output rd, out_valid, out_data
    );
endinterface

// File: rtl/mmio_outport_fifo_sync.sv
// fifo_sync
// Single-clock FIFO with registered pointers and an occupancy counter.
// A push while full is accepted only when a pop happens in the same cycle.
// Ports:
//   clk    clock
//   reset  asynchronous active-low reset
//   push   write request, din written when accepted
//   pop    read request, ignored while empty
//   dout   head word (combinational from read pointer)
//   empty, full, count  occupancy status
module fifo_sync #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wrPtr;
    logic [AW-1:0]    rdPtr;
    logic             doPush;
    logic             doPop;

    assign empty  = (count == '0);
    assign full   = (count == FULL_COUNT);
    assign doPop  = pop & ~empty;
    // A slot frees up in the same edge when the head is popped, so a full
    // FIFO can still take the incoming word.
    assign doPush = push & (~full | doPop);
    assign dout   = mem[rdPtr];

    // Storage has no reset; stale entries are never visible past count.
    always_ff @(posedge clk) begin
        if (doPush) begin
            mem[wrPtr] <= din;
        end
    end

    // Pointers wrap naturally at DEPTH since DEPTH is a power of two.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) begin
                wrPtr <= wrPtr + AW'(1);
            end
            if (doPop) begin
                rdPtr <= rdPtr + AW'(1);
            end
            case ({doPush, doPop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mmio_outport.sv
// mmio_outport
// Memory-mapped output peripheral. Stores to DATA push into a FIFO that
// drains to a valid/ready sink; loads return STATUS (count/empty/full/
// overflow) and TXCNT (number of drained words). rd is 0 outside the window
// so it can be ORed into the load-data path.
// Ports:
//   clk    clock
//   reset  asynchronous active-low reset
//   bus    mmio_outport_if.slave: we/a/wd/rd CPU side, out_* stream side
module mmio_outport #(
    parameter logic [31:0] BASE  = 32'hFFFF_0000,
    parameter int          DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    mmio_outport_if.slave        bus
);

    import mmio_pkg::*;

    localparam int AW = $clog2(DEPTH);

    logic          hit;
    logic [1:0]    off;
    logic          push;
    logic          pop;
    logic          drop;
    logic          ovfClear;
    logic          txWrite;
    logic          empty;
    logic          full;
    logic [AW:0]   count;
    logic          overflow;
    logic [31:0]   txcnt;
    status_t       statusWord;
    logic          unusedAddrBits;

    assign unusedAddrBits = ^bus.a[1:0];

    assign hit  = (bus.a[31:4] == BASE[31:4]);
    assign off  = bus.a[3:2];
    assign push = bus.we & hit & (off == OFF_DATA);
    assign pop  = bus.out_valid & bus.out_ready;
    // The FIFO takes a full-time push only when a pop frees a slot.
    assign drop = push & full & ~pop;
    assign ovfClear = bus.we & hit & (off == OFF_STATUS) & bus.wd[ST_OVF];
    assign txWrite  = bus.we & hit & (off == OFF_TXCNT);

    fifo_sync #(
        .WIDTH (32),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .din   (bus.wd),
        .pop   (pop),
        .dout  (bus.out_data),
        .empty (empty),
        .full  (full),
        .count (count)
    );

    assign bus.out_valid = ~empty;

    // Sticky overflow: a drop in the same cycle as a clear wins.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (ovfClear) begin
            overflow <= 1'b0;
        end
    end

    // A CPU write to TXCNT takes priority over a concurrent pop.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            txcnt <= '0;
        end else if (txWrite) begin
            txcnt <= bus.wd;
        end else if (pop) begin
            txcnt <= txcnt + 32'd1;
        end
    end

    always_comb begin
        statusWord          = '0;
        statusWord.count    = 8'(count);
        statusWord.empty    = empty;
        statusWord.full     = full;
        statusWord.overflow = overflow;
    end

    // DATA and the reserved slot read as zero; loads never pop.
    always_comb begin
        bus.rd = '0;
        if (hit) begin
            case (off)
                OFF_STATUS: bus.rd = statusWord;
                OFF_TXCNT:  bus.rd = txcnt;
                default:    bus.rd = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_outport.sv
// tb_mmio_outport
// Directed walk through the peripheral's main behaviours followed by a
// randomized phase, all compared against a queue-based reference model.
module tb_mmio_outport;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] DATA_A   = 32'hFFFF_0000;
    localparam logic [31:0] STATUS_A = 32'hFFFF_0004;
    localparam logic [31:0] TX_A     = 32'hFFFF_0008;
    localparam logic [31:0] RSVD_A   = 32'hFFFF_000C;

    logic clk;
    logic reset;

    mmio_outport_if bus ();

    mmio_outport #(
        .BASE  (32'hFFFF_0000),
        .DEPTH (DEPTH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int testsRun  = 0;
    int failCount = 0;

    logic [31:0] q[$];
    logic        modelOvf = 1'b0;
    logic [31:0] modelTx  = '0;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        testsRun++;
        assert (got === exp) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] modelStatus();
        int s;
        s = q.size();
        if (q.size() == 0)     s += 256;
        if (q.size() == DEPTH) s += 512;
        if (modelOvf)          s += 1024;
        return 32'(s);
    endfunction

    function automatic logic [31:0] modelRd(input logic [31:0] addr);
        if (addr[31:4] != DATA_A[31:4]) return 32'h0;
        if (addr[3:2] == 2'd1) return modelStatus();
        if (addr[3:2] == 2'd2) return modelTx;
        return 32'h0;
    endfunction

    task automatic modelReset();
        q.delete();
        modelOvf = 1'b0;
        modelTx  = '0;
    endtask

    // Drive inputs (called at a falling edge) and let combinational paths settle.
    task automatic applyStimulus(input logic we, input logic [31:0] a,
                                 input logic [31:0] wd, input logic ready);
        bus.we        = we;
        bus.a         = a;
        bus.wd        = wd;
        bus.out_ready = ready;
        #1;
    endtask

    task automatic checkModel();
        checkOutput("out_valid", {31'b0, bus.out_valid}, {31'b0, q.size() != 0});
        if (q.size() != 0) checkOutput("out_data", bus.out_data, q[0]);
        checkOutput("rd", bus.rd, modelRd(bus.a));
    endtask

    // Advance the model by the effect of the currently driven inputs, then
    // take one clock and return to the falling edge.
    task automatic cycle();
        logic inWin;
        logic popNow;
        logic pushNow;
        logic wasFull;
        logic dropped;
        inWin   = (bus.a[31:4] == DATA_A[31:4]);
        popNow  = (q.size() != 0) && bus.out_ready;
        pushNow = bus.we && inWin && (bus.a[3:2] == 2'd0);
        wasFull = (q.size() == DEPTH);
        dropped = 1'b0;
        if (popNow) void'(q.pop_front());
        if (pushNow) begin
            if (!wasFull || popNow) q.push_back(bus.wd);
            else dropped = 1'b1;
        end
        if (dropped) modelOvf = 1'b1;
        else if (bus.we && inWin && bus.a[3:2] == 2'd1 && bus.wd[10]) modelOvf = 1'b0;
        if (bus.we && inWin && bus.a[3:2] == 2'd2) modelTx = bus.wd;
        else if (popNow) modelTx = modelTx + 32'd1;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic step(input logic we, input logic [31:0] a,
                        input logic [31:0] wd, input logic ready);
        applyStimulus(we, a, wd, ready);
        checkModel();
        cycle();
    endtask

    logic [31:0] vals [4];
    logic [31:0] drain2 [4];

    initial begin
        vals   = '{32'h11, 32'h22, 32'h33, 32'h44};
        drain2 = '{32'h22, 32'h33, 32'h44, 32'h66};
        reset = 1'b0;
        bus.we = 1'b0; bus.a = '0; bus.wd = '0; bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // Idle after reset
        applyStimulus(1'b0, STATUS_A, 32'h0, 1'b0);
        checkOutput("reset_status", bus.rd, 32'h0000_0100);
        checkOutput("reset_valid", {31'b0, bus.out_valid}, 32'h0);
        cycle();
        applyStimulus(1'b0, TX_A, 32'h0, 1'b0);
        checkOutput("reset_txcnt", bus.rd, 32'h0);
        cycle();

        // Fill, then overflow with 55
        for (int i = 0; i < 4; i++) step(1'b1, DATA_A, vals[i], 1'b0);
        applyStimulus(1'b0, STATUS_A, 32'h0, 1'b0);
        checkOutput("full_status", bus.rd, 32'h0000_0204);
        cycle();
        step(1'b1, DATA_A, 32'h55, 1'b0);
        applyStimulus(1'b0, STATUS_A, 32'h0, 1'b0);
        checkOutput("ovf_status", bus.rd, 32'h0000_0604);
        cycle();

        // Drain in order; 55 must not appear
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, TX_A, 32'h0, 1'b1);
            checkOutput("drain_data", bus.out_data, vals[i]);
            checkModel();
            cycle();
        end
        applyStimulus(1'b0, TX_A, 32'h0, 1'b0);
        checkOutput("drain_empty", {31'b0, bus.out_valid}, 32'h0);
        checkOutput("drain_txcnt", bus.rd, 32'd4);
        cycle();

        // Push while full with a simultaneous pop
        for (int i = 0; i < 4; i++) step(1'b1, DATA_A, vals[i], 1'b0);
        applyStimulus(1'b1, DATA_A, 32'h66, 1'b1);
        checkOutput("pushpop_head", bus.out_data, 32'h11);
        cycle();
        applyStimulus(1'b0, STATUS_A, 32'h0, 1'b0);
        checkOutput("pushpop_status", bus.rd, 32'h0000_0604);
        cycle();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, DATA_A, 32'h0, 1'b1);
            checkOutput("drain2_data", bus.out_data, drain2[i]);
            checkOutput("data_read_zero", bus.rd, 32'h0);
            cycle();
        end

        // Overflow clear, TXCNT wrap
        step(1'b1, STATUS_A, 32'h400, 1'b0);
        applyStimulus(1'b0, STATUS_A, 32'h0, 1'b0);
        checkOutput("ovf_cleared", bus.rd, 32'h0000_0100);
        cycle();
        step(1'b1, TX_A, 32'hFFFF_FFFF, 1'b0);
        step(1'b1, DATA_A, 32'h77, 1'b0);
        applyStimulus(1'b0, DATA_A, 32'h0, 1'b0);
        checkOutput("no_pop_on_load", {31'b0, bus.out_valid}, 32'h1);
        cycle();
        applyStimulus(1'b0, TX_A, 32'h0, 1'b1);
        checkOutput("wrap_data", bus.out_data, 32'h77);
        cycle();
        applyStimulus(1'b0, TX_A, 32'h0, 1'b0);
        checkOutput("txcnt_wrap", bus.rd, 32'h0);
        cycle();

        // Outside the window and reserved slot
        applyStimulus(1'b0, 32'h0000_0054, 32'h0, 1'b0);
        checkOutput("outside_rd", bus.rd, 32'h0);
        cycle();
        step(1'b1, RSVD_A, 32'hDEAD_BEEF, 1'b0);
        step(1'b0, RSVD_A, 32'h0, 1'b0);
        step(1'b0, STATUS_A, 32'h0, 1'b0);

        // Reset in the middle of a drain
        step(1'b1, DATA_A, 32'h88, 1'b0);
        step(1'b1, DATA_A, 32'h99, 1'b0);
        step(1'b0, STATUS_A, 32'h0, 1'b1);
        applyStimulus(1'b0, STATUS_A, 32'h0, 1'b1);
        checkOutput("pre_reset_valid", {31'b0, bus.out_valid}, 32'h1);
        reset = 1'b0;
        #1;
        checkOutput("async_reset_valid", {31'b0, bus.out_valid}, 32'h0);
        modelReset();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        applyStimulus(1'b0, STATUS_A, 32'h0, 1'b0);
        checkOutput("post_reset_status", bus.rd, 32'h0000_0100);
        cycle();

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            int sel;
            logic [31:0] addr;
            sel = int'($urandom_range(0, 6));
            case (sel)
                0, 1, 2: addr = DATA_A;
                3:       addr = STATUS_A;
                4:       addr = ($urandom_range(0, 7) == 0) ? TX_A : STATUS_A;
                5:       addr = RSVD_A;
                default: addr = $urandom() & 32'h7FFF_FFFC;
            endcase
            step(1'($urandom_range(0, 1)), addr, $urandom(), 1'($urandom_range(0, 2) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

endmodule

// File: doc/mmio_outport.md
Name: mmio_outport

Overview:
- Memory-mapped output peripheral that sits on the processor data bus as a responder, in parallel with data memory.
- CPU stores to its window push words into a small FIFO, which drains to an external valid/ready sink one word per accepted beat.
- CPU loads from the window return status and a drained-word counter.
- Top-level glue ORs its rd into the load-data path; it drives 0 outside the window.

Parameters:
- BASE, 32'hFFFF_0000: window base address. 16-byte aligned; a[3:0] of BASE are ignored.
- DEPTH, 4: FIFO entries. Power of 2, range 2..128.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- we  in  1  CPU store strobe (memwrite).
- a  in  32  CPU byte address (ALU result).
- wd  in  32  CPU store data.
- rd  out  32  load data. Combinational, same cycle as a; 0 when a is outside the window.
- out_valid  out  1  FIFO non-empty.
- out_data  out  32  FIFO head word; valid while out_valid.
- out_ready  in  1  sink accepts the head when out_valid & out_ready.

Behaviour:
- Decode: hit = (a[31:4] == BASE[31:4]); off = a[3:2].
  - off 0: DATA.
  - off 1: STATUS.
  - off 2: TXCNT.
  - off 3: reserved; reads 0, writes ignored.
- Reset (reset low, asynchronous): FIFO empty, rd/wr pointers 0, overflow 0, TXCNT 0; out_valid 0 immediately.
- Register widths:
  - Pointers: $clog2(DEPTH) bits; wrap naturally modulo DEPTH.
  - count: $clog2(DEPTH)+1 bits.
- push = we & hit & off==0.
- pop = out_valid & out_ready.
- DATA write:
  - Not full: wd written at wr pointer; pointer increments.
  - Full and no pop this cycle: word dropped; overflow sticky set to 1.
  - Full with pop in the same cycle: push accepted; count unchanged.
- Empty FIFO, push: no bypass. out_valid rises the cycle after the push edge (1-cycle latency).
- Push and pop together, non-full and non-empty: count unchanged; both pointers advance.
- Pop while empty: impossible (out_valid=0).
- out_data = mem[rd pointer], combinational. Its value is don't-care while out_valid=0; the bench must not check it then.
- STATUS read:
  - [7:0] count, zero-extended.
  - [8] empty.
  - [9] full.
  - [10] overflow.
  - [31:11] 0.
- STATUS write: wd[10]=1 clears overflow. If a drop occurs in the same cycle, set wins, so overflow stays 1.
- TXCNT:
  - 32-bit counter; increments on each pop; wraps FFFF_FFFF→0.
  - A write loads wd. If a pop occurs in the same cycle, the written value wins and that pop is not counted.
- DATA read: returns 0 and has no side effect (no pop on load).
- rd reflects state before the current edge; it is purely combinational from a and the registers.
- we with hit but off==3: no state change.
- Reset asserted mid-stream: FIFO contents are discarded and out_valid drops asynchronously. Memory array contents are don't-care.

Decomposition:
- Package mmio_pkg:
  - offset constants OFF_DATA=0, OFF_STATUS=1, OFF_TXCNT=2.
  - STATUS bit positions ST_EMPTY=8, ST_FULL=9, ST_OVF=10.
  - packed struct for the STATUS word.
- Sub-module fifo_sync #(WIDTH, DEPTH):
  - Ports: clk, reset, push, din, pop, dout, empty, full, count.
  - Implements the accept-on-full-with-pop rule internally.
- mmio_outport contains decode, overflow, TXCNT and the rd mux.

Test Plan:
- Reset then idle: STATUS read at FFFF0004 → 32'h0000_0100; TXCNT = 0; out_valid = 0.
- out_ready=0; store 11,22,33,44 to FFFF0000 → STATUS = 32'h0000_0204. Fifth store of 55 → STATUS = 32'h0000_0604.
- Raise out_ready → out_data 11,22,33,44 on consecutive cycles; then out_valid=0; TXCNT = 4; 55 never appears.
- FIFO full, out_ready=1, store 66 in the same cycle as the pop of 11 → count stays 4, overflow unchanged; 66 is drained last.
- Write FFFF0004 with wd=32'h400 → overflow cleared. Write TXCNT=32'hFFFF_FFFF, then one pop → TXCNT = 0.
- Load from 32'h0000_0054 → rd = 0. Assert reset low mid-drain → out_valid=0 with no clock edge; STATUS = 32'h0000_0100 after release.
